// File: rtl/motor_ramp_sequencer.sv
//------------------------------------------------------------------------------
// Module   : motor_ramp_sequencer
// Brief    : Rate-limited two-motor period ramping with braked reversals and
//            a load strobe for the PWM motor controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module motor_ramp_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int STEP     = 4,
    parameter int DWELL    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_m1_sign,
    input  logic [6:0] cmd_m1_period,
    input  logic       cmd_m2_sign,
    input  logic [6:0] cmd_m2_period,
    output logic       motor1_sign,
    output logic [6:0] motor1_period,
    output logic       motor2_sign,
    output logic [6:0] motor2_period,
    output logic       mc_load,
    output logic       busy
);

    localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DW = $clog2(DWELL + 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [7:0]      c_STEP = 8'(STEP);

    typedef enum logic [1:0] {
        ST_AT_TARGET = 2'd0,
        ST_RAMP      = 2'd1,
        ST_BRAKE     = 2'd2,
        ST_DWELL     = 2'd3
    } state_t;

    logic [c_TW-1:0] r_tick_cnt;
    logic            r_ready;
    logic            r_mc_load;
    logic            r_busy;
    logic            w_tick;
    logic            w_accept;
    logic [1:0]      w_chg;
    logic [1:0]      w_busy_nx;
    logic [1:0]      w_sign;
    logic [1:0][6:0] w_period;
    logic [1:0]      w_cmd_sign;
    logic [1:0][6:0] w_cmd_period;

    assign w_tick       = (r_tick_cnt == c_TICK_LAST);
    assign w_accept     = cmd_valid & r_ready;
    assign w_cmd_sign   = {cmd_m2_sign, cmd_m1_sign};
    assign w_cmd_period = {cmd_m2_period, cmd_m1_period};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_ready    <= 1'b0;
            r_mc_load  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_ready    <= 1'b1;
            r_mc_load  <= |w_chg;
            r_busy     <= |w_busy_nx;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_motor
        state_t          r_state, w_state_nx;
        logic            r_sign, w_sign_nx, r_tsign, w_tsign_nx;
        logic [6:0]      r_period, w_period_nx, r_tper, w_tper_nx;
        logic [c_DW-1:0] r_dw, w_dw_nx;
        logic [7:0]      w_up, w_dn;
        logic [6:0]      w_dec;

        // Tick step runs first on the old targets; an accepted command then
        // re-evaluates the state against that stepped result.
        always_comb begin
            w_state_nx  = r_state;
            w_sign_nx   = r_sign;
            w_period_nx = r_period;
            w_tsign_nx  = r_tsign;
            w_tper_nx   = r_tper;
            w_dw_nx     = r_dw;
            w_up        = {1'b0, r_period} + c_STEP;
            w_dn        = {1'b0, r_period} - c_STEP;
            w_dec       = w_dn[7] ? 7'd0 : w_dn[6:0];

            if (w_tick) begin
                case (r_state)
                    ST_RAMP: begin
                        if (r_sign != r_tsign) begin
                            if (r_period == 7'd0) begin
                                w_sign_nx = r_tsign;
                            end else begin
                                w_period_nx = w_dec;
                                w_state_nx  = ST_BRAKE;
                            end
                        end else if (r_period < r_tper) begin
                            w_period_nx = (w_up >= {1'b0, r_tper}) ? r_tper : w_up[6:0];
                        end else begin
                            w_period_nx = (w_dn[7] || (w_dn[6:0] <= r_tper)) ? r_tper : w_dn[6:0];
                        end
                        if ((w_sign_nx == r_tsign) && (w_period_nx == r_tper))
                            w_state_nx = ST_AT_TARGET;
                    end
                    ST_BRAKE: begin
                        w_period_nx = w_dec;
                        if (w_dec == 7'd0) begin
                            w_state_nx = ST_DWELL;
                            w_dw_nx    = '0;
                        end
                    end
                    ST_DWELL: begin
                        if (r_dw == c_DWELL_LAST) begin
                            w_sign_nx  = r_tsign;
                            w_dw_nx    = '0;
                            w_state_nx = (r_tper == 7'd0) ? ST_AT_TARGET : ST_RAMP;
                        end else begin
                            w_dw_nx = r_dw + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_accept) begin
                w_tsign_nx = w_cmd_sign[i];
                w_tper_nx  = w_cmd_period[i];
                case (w_state_nx)
                    ST_DWELL: begin
                        if (w_cmd_sign[i] == w_sign_nx) begin
                            w_state_nx = (w_cmd_period[i] == 7'd0) ? ST_AT_TARGET : ST_RAMP;
                            w_dw_nx    = '0;
                        end
                    end
                    ST_BRAKE: begin
                        if (w_cmd_sign[i] == w_sign_nx)
                            w_state_nx = (w_cmd_period[i] == w_period_nx) ? ST_AT_TARGET : ST_RAMP;
                    end
                    default: begin
                        if ((w_cmd_sign[i] == w_sign_nx) && (w_cmd_period[i] == w_period_nx))
                            w_state_nx = ST_AT_TARGET;
                        else if ((w_cmd_sign[i] == w_sign_nx) || (w_period_nx == 7'd0))
                            w_state_nx = ST_RAMP;
                        else
                            w_state_nx = ST_BRAKE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= ST_AT_TARGET;
                r_sign   <= 1'b0;
                r_period <= '0;
                r_tsign  <= 1'b0;
                r_tper   <= '0;
                r_dw     <= '0;
            end else begin
                r_state  <= w_state_nx;
                r_sign   <= w_sign_nx;
                r_period <= w_period_nx;
                r_tsign  <= w_tsign_nx;
                r_tper   <= w_tper_nx;
                r_dw     <= w_dw_nx;
            end
        end

        assign w_chg[i]     = (w_sign_nx != r_sign) || (w_period_nx != r_period);
        assign w_busy_nx[i] = (w_state_nx != ST_AT_TARGET);
        assign w_sign[i]    = r_sign;
        assign w_period[i]  = r_period;
    end

    assign cmd_ready     = r_ready;
    assign mc_load       = r_mc_load;
    assign busy          = r_busy;
    assign motor1_sign   = w_sign[0];
    assign motor1_period = w_period[0];
    assign motor2_sign   = w_sign[1];
    assign motor2_period = w_period[1];

endmodule

`default_nettype wire

// File: tb/tb_motor_ramp_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_motor_ramp_sequencer
// Brief    : Scoreboard bench for motor_ramp_sequencer (TICK_DIV=4, STEP=4, DWELL=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_motor_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_m1_sign = 1'b0;
    logic [6:0] cmd_m1_period = '0;
    logic       cmd_m2_sign = 1'b0;
    logic [6:0] cmd_m2_period = '0;
    logic       motor1_sign, motor2_sign;
    logic [6:0] motor1_period, motor2_period;
    logic       mc_load, busy;

    motor_ramp_sequencer #(.TICK_DIV(4), .STEP(4), .DWELL(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m1_sign(cmd_m1_sign), .cmd_m1_period(cmd_m1_period),
        .cmd_m2_sign(cmd_m2_sign), .cmd_m2_period(cmd_m2_period),
        .motor1_sign(motor1_sign), .motor1_period(motor1_period),
        .motor2_sign(motor2_sign), .motor2_period(motor2_period),
        .mc_load(mc_load), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s1;
        logic [6:0] p1;
        logic       s2;
        logic [6:0] p2;
        int         gap;   // cycles since previous load, 0 = not checked
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_load = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every load strobe must match the next expected output set.
    always @(negedge clk) begin
        if (reset && mc_load) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_load: got m1=%0d/%0d m2=%0d/%0d, expected no load",
                         motor1_sign, motor1_period, motor2_sign, motor2_period);
            end else begin
                e = sb.pop_front();
                if ({motor1_sign, motor1_period, motor2_sign, motor2_period} !== {e.s1, e.p1, e.s2, e.p2}) begin
                    n_fail++;
                    $display("FAIL load_values: got m1=%0d/%0d m2=%0d/%0d, expected m1=%0d/%0d m2=%0d/%0d",
                             motor1_sign, motor1_period, motor2_sign, motor2_period, e.s1, e.p1, e.s2, e.p2);
                end
                if (e.gap != 0) begin
                    n_checks++;
                    if (cyc - last_load != e.gap) begin
                        n_fail++;
                        $display("FAIL load_gap: got %0d cycles, expected %0d (m1=%0d/%0d)",
                                 cyc - last_load, e.gap, e.s1, e.p1);
                    end
                end
            end
            last_load = cyc;
        end
    end

    task automatic push(input logic s1, input int p1, input logic s2, input int p2, input int gap);
        exp_t x;
        x.s1 = s1; x.p1 = 7'(p1); x.s2 = s2; x.p2 = 7'(p2); x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic s1, input int p1, input logic s2, input int p2);
        @(negedge clk);
        cmd_m1_sign = s1; cmd_m1_period = 7'(p1);
        cmd_m2_sign = s2; cmd_m2_period = 7'(p2);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d, expected idle", name, busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_m1(input string name, input int p);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (motor1_period == 7'(p)) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got m1 period %0d, expected %0d", name, motor1_period, p);
        end
    endtask

    initial begin
        int p;
        bit first;
        repeat (3) @(negedge clk);
        check("rst_m1_sign", motor1_sign, 0);
        check("rst_m1_period", motor1_period, 0);
        check("rst_m2_sign", motor2_sign, 0);
        check("rst_m2_period", motor2_period, 0);
        check("rst_mc_load", mc_load, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);
        repeat (6) @(negedge clk);
        check("idle_m1_period", motor1_period, 0);

        // Ramp up with clamp to target
        push(0, 4, 0, 0, 0); push(0, 8, 0, 0, 4); push(0, 10, 0, 0, 4);
        send(0, 10, 0, 0);
        check("busy_after_cmd", busy, 1);
        wait_idle("ramp_up");
        check("ramp_up_m1", motor1_period, 10);
        check("ramp_up_busy", busy, 0);

        // Reversal: brake, dwell two ticks, flip, ramp
        push(0, 6, 0, 0, 0); push(0, 2, 0, 0, 4); push(0, 0, 0, 0, 4);
        push(1, 0, 0, 0, 8); push(1, 4, 0, 0, 4); push(1, 6, 0, 0, 4);
        send(1, 6, 0, 0);
        wait_idle("reverse");
        check("reverse_m1_sign", motor1_sign, 1);

        // Retarget to current sign during dwell: no flip
        push(1, 2, 0, 0, 0); push(1, 0, 0, 0, 4);
        send(0, 10, 0, 0);
        wait_m1("reach_dwell", 0);
        push(1, 4, 0, 0, 4); push(1, 8, 0, 0, 4);
        send(1, 8, 0, 0);
        wait_idle("dwell_retarget");
        check("dwell_retarget_sign", motor1_sign, 1);

        // Long ramp on both motors, then clamp at 127
        push(1, 12, 0, 4, 0); push(1, 16, 0, 5, 4);
        for (int k = 3; k <= 29; k++) push(1, 8 + 4 * k, 0, 5, 4);
        push(1, 125, 0, 5, 4);
        send(1, 125, 0, 5);
        wait_idle("to_125");
        push(1, 127, 0, 5, 0);
        send(1, 127, 0, 5);
        wait_idle("to_127");
        check("clamp_127", motor1_period, 127);

        // Ramp down to 2, then 2 -> 0 without underflow
        p = 127; first = 1;
        while (p != 2) begin
            p = (p - 4 < 2) ? 2 : p - 4;
            push(1, p, 0, 5, first ? 0 : 4);
            first = 0;
        end
        send(1, 2, 0, 5);
        wait_idle("to_2");
        push(1, 0, 0, 5, 0);
        send(1, 0, 0, 5);
        wait_idle("to_0");
        check("floor_0", motor1_period, 0);

        // Motor 2 reversal with dwell
        push(1, 0, 0, 1, 0); push(1, 0, 0, 0, 4); push(1, 0, 1, 0, 8); push(1, 0, 1, 3, 4);
        send(1, 0, 1, 3);
        wait_idle("m2_reverse");

        // Motor 1 sign change from period 0: flip on next tick, no dwell
        push(0, 0, 1, 3, 0); push(0, 4, 1, 3, 4);
        send(0, 4, 1, 3);
        wait_idle("zero_flip");

        // Reset mid-ramp
        push(0, 8, 1, 3, 0); push(0, 12, 1, 3, 4); push(0, 16, 1, 3, 4); push(0, 20, 1, 3, 4);
        send(0, 20, 1, 3);
        wait_m1("mid_ramp", 8);
        #1 reset = 1'b0;
        #1;
        check("async_m1_period", motor1_period, 0);
        check("async_m2_period", motor2_period, 0);
        check("async_m2_sign", motor2_sign, 0);
        check("async_mc_load", mc_load, 0);
        check("async_busy", busy, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no_resume_m1", motor1_period, 0);
        check("no_resume_busy", busy, 0);
        check("ready_again", cmd_ready, 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
